// File: rtl/pc_seq_ctrl.sv
// ---------------------------------------------------------------------------
// pc_seq_ctrl
//   Next-PC sequencer and stall controller for the fetch-stage PC register.
//   Every cycle it drives the PC register's next-value input (pc_next) and
//   its hold input (pc_stall). It arbitrates sequential fetch, branch, jump,
//   exception-return and trap redirects. A redirect that arrives while the
//   pipeline is frozen is parked and replayed when the freeze lifts. The
//   block also owns the EPC/cause registers and the single-level trap flag.
//
// Configuration macro:
//   PCSEQ_STALL_TIMEOUT_EN - when defined, a watchdog counts consecutive
//   stalled cycles in RUN/HOLD. It forces a trap with cause 4'hF once the
//   count reaches STALL_LIMIT-1 outside a handler. The STALL_LIMIT parameter
//   exists only in that build.
//
// Ports:
//   clk          in   1   clock, rising edge
//   rst          in   1   asynchronous reset, active-low
//   pc_cur       in  32   current PC (PC register output)
//   hazard_stall in   1   stall request from hazard unit
//   imem_busy    in   1   instruction memory not ready
//   br_taken     in   1   resolved taken branch this cycle
//   br_target    in  32   branch target
//   jmp_valid    in   1   jump this cycle
//   jmp_target   in  32   jump target
//   eret         in   1   exception return (target = epc)
//   trap_req     in   1   trap request
//   trap_cause   in   4   trap cause code
//   pc_next      out 32   next PC (combinational)
//   pc_stall     out  1   hold PC (combinational)
//   flush_if     out  1   squash IF/ID instruction (combinational)
//   epc          out 32   saved exception PC (registered)
//   cause        out  4   saved trap cause (registered)
//   in_trap      out  1   handler active, nested traps masked (registered)
// ---------------------------------------------------------------------------
module pc_seq_ctrl #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter logic [31:0] TRAP_VECTOR = 32'h0000_0080
`ifdef PCSEQ_STALL_TIMEOUT_EN
  ,
  parameter int unsigned STALL_LIMIT = 16
`endif
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_cur,
  input  logic        hazard_stall,
  input  logic        imem_busy,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  input  logic        jmp_valid,
  input  logic [31:0] jmp_target,
  input  logic        eret,
  input  logic        trap_req,
  input  logic [3:0]  trap_cause,
  output logic [31:0] pc_next,
  output logic        pc_stall,
  output logic        flush_if,
  output logic [31:0] epc,
  output logic [3:0]  cause,
  output logic        in_trap
);

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_HOLD = 2'd1,
    ST_TRAP = 2'd2
  } state_e;

  // Sequential successor of a PC; the 32-bit add wraps naturally.
  function automatic logic [31:0] pc_inc(input logic [31:0] pc);
    pc_inc = pc + 32'd4;
  endfunction

  // Registered state
  state_e      state_q,       state_d;
  logic [31:0] epc_q,         epc_d;
  logic [3:0]  cause_q,       cause_d;
  logic        in_trap_q,     in_trap_d;
  logic        pend_valid_q,  pend_valid_d;
  logic [31:0] pend_target_q, pend_target_d;
  logic        pend_eret_q,   pend_eret_d;

  // Combinational helpers
  logic        stall_s;
  logic        redir_s;
  logic [31:0] redir_target_s;
  logic        tmo_fire_s;
  logic        trap_take_s;
  logic [3:0]  trap_cause_s;
  logic [31:0] pc_next_s;
  logic        pc_stall_s;
  logic        flush_if_s;

  assign stall_s = hazard_stall | imem_busy;
  assign redir_s = eret | jmp_valid | br_taken;

  // Redirect target selection: eret beats jump, jump beats branch.
  always_comb begin
    if (eret) begin
      redir_target_s = epc_q;
    end else if (jmp_valid) begin
      redir_target_s = jmp_target;
    end else if (br_taken) begin
      redir_target_s = br_target;
    end else begin
      redir_target_s = pc_inc(pc_cur);
    end
  end

`ifdef PCSEQ_STALL_TIMEOUT_EN
  localparam logic [15:0] STALL_LAST = 16'(STALL_LIMIT - 1);

  logic [15:0] stall_cnt_q, stall_cnt_d;

  // The watchdog only matters outside TRAP; TRAP ends on its own once
  // instruction memory is ready.
  assign tmo_fire_s = (state_q != ST_TRAP) && (stall_cnt_q == STALL_LAST);
`else
  assign tmo_fire_s = 1'b0;
`endif

  // A forced timeout trap obeys the same single-level masking as trap_req.
  assign trap_take_s  = (trap_req | tmo_fire_s) & ~in_trap_q;
  assign trap_cause_s = tmo_fire_s ? 4'hF : trap_cause;

  // Next-state and combinational output decode for the sequencer FSM.
  always_comb begin
    state_d       = state_q;
    epc_d         = epc_q;
    cause_d       = cause_q;
    in_trap_d     = in_trap_q;
    pend_valid_d  = pend_valid_q;
    pend_target_d = pend_target_q;
    pend_eret_d   = pend_eret_q;
    pc_next_s     = pc_inc(pc_cur);
    pc_stall_s    = 1'b1;
    flush_if_s    = 1'b0;

    case (state_q)
      ST_RUN: begin
        if (trap_take_s) begin
          // Trap wins over stalls and redirects; freeze PC, squash IF/ID.
          epc_d      = pc_cur;
          cause_d    = trap_cause_s;
          state_d    = ST_TRAP;
          pc_stall_s = 1'b1;
          flush_if_s = 1'b1;
        end else if (redir_s) begin
          if (stall_s) begin
            // Park the redirect until the pipeline unfreezes.
            pend_target_d = redir_target_s;
            pend_valid_d  = 1'b1;
            pend_eret_d   = eret;
            state_d       = ST_HOLD;
            pc_stall_s    = 1'b1;
            flush_if_s    = 1'b0;
          end else begin
            pc_next_s  = redir_target_s;
            pc_stall_s = 1'b0;
            flush_if_s = 1'b1;
            if (eret) begin
              in_trap_d = 1'b0;
            end else begin
              in_trap_d = in_trap_q;
            end
          end
        end else begin
          pc_stall_s = stall_s;
          flush_if_s = 1'b0;
        end
      end

      ST_HOLD: begin
        if (trap_take_s) begin
          // The parked target is the PC the handler must return to.
          epc_d        = pend_target_q;
          cause_d      = trap_cause_s;
          pend_valid_d = 1'b0;
          state_d      = ST_TRAP;
          pc_stall_s   = 1'b1;
          flush_if_s   = 1'b1;
        end else if (!pend_valid_q) begin
          // Nothing parked (unreachable in normal flow): fall back to RUN.
          state_d    = ST_RUN;
          pc_stall_s = 1'b1;
          flush_if_s = 1'b0;
        end else if (stall_s) begin
          // Still frozen; fresh redirects are ignored while one is parked.
          pc_stall_s = 1'b1;
          flush_if_s = 1'b0;
        end else begin
          pc_next_s    = pend_target_q;
          pc_stall_s   = 1'b0;
          flush_if_s   = 1'b1;
          pend_valid_d = 1'b0;
          state_d      = ST_RUN;
          if (pend_eret_q) begin
            in_trap_d = 1'b0;
          end else begin
            in_trap_d = in_trap_q;
          end
        end
      end

      ST_TRAP: begin
        // Only imem readiness gates the handler fetch; hazards, new traps
        // and redirects are ignored here.
        if (imem_busy) begin
          pc_stall_s = 1'b1;
          flush_if_s = 1'b0;
        end else begin
          pc_next_s  = TRAP_VECTOR;
          pc_stall_s = 1'b0;
          flush_if_s = 1'b1;
          in_trap_d  = 1'b1;
          state_d    = ST_RUN;
        end
      end

      default: begin
        // Illegal encoding: recover to RUN with nothing parked.
        state_d      = ST_RUN;
        pend_valid_d = 1'b0;
        pc_stall_s   = 1'b1;
        flush_if_s   = 1'b0;
      end
    endcase
  end

`ifdef PCSEQ_STALL_TIMEOUT_EN
  // Watchdog next value: count consecutive stalled cycles in one RUN/HOLD
  // stay; any released cycle or state change restarts from zero.
  always_comb begin
    if ((state_q != ST_TRAP) && (state_d == state_q) && pc_stall_s) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end else begin
      stall_cnt_d = 16'd0;
    end
  end
`endif

  // State register for the sequencer, trap bookkeeping and parked redirect.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= ST_RUN;
      epc_q         <= 32'h0000_0000;
      cause_q       <= 4'h0;
      in_trap_q     <= 1'b0;
      pend_valid_q  <= 1'b0;
      pend_target_q <= 32'h0000_0000;
      pend_eret_q   <= 1'b0;
`ifdef PCSEQ_STALL_TIMEOUT_EN
      stall_cnt_q   <= 16'd0;
`endif
    end else begin
      state_q       <= state_d;
      epc_q         <= epc_d;
      cause_q       <= cause_d;
      in_trap_q     <= in_trap_d;
      pend_valid_q  <= pend_valid_d;
      pend_target_q <= pend_target_d;
      pend_eret_q   <= pend_eret_d;
`ifdef PCSEQ_STALL_TIMEOUT_EN
      stall_cnt_q   <= stall_cnt_d;
`endif
    end
  end

  // While reset is low, the PC register is held at RESET_PC.
  assign pc_next  = rst ? pc_next_s  : RESET_PC;
  assign pc_stall = rst ? pc_stall_s : 1'b1;
  assign flush_if = rst ? flush_if_s : 1'b0;

  assign epc     = epc_q;
  assign cause   = cause_q;
  assign in_trap = in_trap_q;

endmodule

// File: tb/tb_pc_seq_ctrl.sv
module tb_pc_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_cur;
  logic        hazard_stall;
  logic        imem_busy;
  logic        br_taken;
  logic [31:0] br_target;
  logic        jmp_valid;
  logic [31:0] jmp_target;
  logic        eret;
  logic        trap_req;
  logic [3:0]  trap_cause;
  logic [31:0] pc_next;
  logic        pc_stall;
  logic        flush_if;
  logic [31:0] epc;
  logic [3:0]  cause;
  logic        in_trap;

  int tests = 0;
  int fails = 0;

  pc_seq_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .pc_cur       (pc_cur),
    .hazard_stall (hazard_stall),
    .imem_busy    (imem_busy),
    .br_taken     (br_taken),
    .br_target    (br_target),
    .jmp_valid    (jmp_valid),
    .jmp_target   (jmp_target),
    .eret         (eret),
    .trap_req     (trap_req),
    .trap_cause   (trap_cause),
    .pc_next      (pc_next),
    .pc_stall     (pc_stall),
    .flush_if     (flush_if),
    .epc          (epc),
    .cause        (cause),
    .in_trap      (in_trap)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Inputs change on the falling edge; checks happen 1 time unit later,
  // well clear of the rising edge.
  task automatic step();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    hazard_stall = 1'b0; imem_busy = 1'b0;
    br_taken = 1'b0; br_target = 32'h0;
    jmp_valid = 1'b0; jmp_target = 32'h0;
    eret = 1'b0; trap_req = 1'b0; trap_cause = 4'h0;
  endtask

  initial begin
    rst = 1'b0; pc_cur = 32'h0;
    idle_inputs();

    // Reset state
    step(); #1;
    chk("rst_pc_next", pc_next, 32'h0);
    chk("rst_pc_stall", {31'h0, pc_stall}, 32'h1);
    chk("rst_flush", {31'h0, flush_if}, 32'h0);
    chk("rst_epc", epc, 32'h0);
    chk("rst_cause", {28'h0, cause}, 32'h0);
    chk("rst_in_trap", {31'h0, in_trap}, 32'h0);

    // Sequential fetch from 0
    step(); rst = 1'b1; pc_cur = 32'h0; #1;
    chk("seq0_next", pc_next, 32'h4);
    chk("seq0_stall", {31'h0, pc_stall}, 32'h0);
    chk("seq0_flush", {31'h0, flush_if}, 32'h0);
    step(); pc_cur = 32'h4; #1;
    chk("seq1_next", pc_next, 32'h8);
    step(); pc_cur = 32'h8; #1;
    chk("seq2_next", pc_next, 32'hC);
    chk("seq2_flush", {31'h0, flush_if}, 32'h0);
    step(); pc_cur = 32'hFFFF_FFFC; #1;
    chk("seq_wrap", pc_next, 32'h0);

    // Branch, no stall
    step(); pc_cur = 32'h40; br_taken = 1'b1; br_target = 32'h100; #1;
    chk("br_next", pc_next, 32'h100);
    chk("br_flush", {31'h0, flush_if}, 32'h1);
    chk("br_stall", {31'h0, pc_stall}, 32'h0);
    step(); br_taken = 1'b0; pc_cur = 32'h100; #1;
    chk("br_after_next", pc_next, 32'h104);
    chk("br_after_flush", {31'h0, flush_if}, 32'h0);

    // Jump under a 3-cycle hazard stall; a branch during HOLD is ignored
    step(); pc_cur = 32'h40; jmp_valid = 1'b1; jmp_target = 32'h200; hazard_stall = 1'b1; #1;
    chk("jmp_h1_stall", {31'h0, pc_stall}, 32'h1);
    chk("jmp_h1_flush", {31'h0, flush_if}, 32'h0);
    step(); jmp_valid = 1'b0; br_taken = 1'b1; br_target = 32'h300; #1;
    chk("jmp_h2_stall", {31'h0, pc_stall}, 32'h1);
    chk("jmp_h2_flush", {31'h0, flush_if}, 32'h0);
    step(); br_taken = 1'b0; #1;
    chk("jmp_h3_stall", {31'h0, pc_stall}, 32'h1);
    chk("jmp_h3_flush", {31'h0, flush_if}, 32'h0);
    step(); hazard_stall = 1'b0; #1;
    chk("jmp_rel_next", pc_next, 32'h200);
    chk("jmp_rel_stall", {31'h0, pc_stall}, 32'h0);
    chk("jmp_rel_flush", {31'h0, flush_if}, 32'h1);
    step(); pc_cur = 32'h200; #1;
    chk("jmp_post_next", pc_next, 32'h204);
    chk("jmp_post_flush", {31'h0, flush_if}, 32'h0);

    // Trap entry wins over a simultaneous branch
    step(); pc_cur = 32'h60; trap_req = 1'b1; trap_cause = 4'h3;
    br_taken = 1'b1; br_target = 32'h300; #1;
    chk("trap_stall", {31'h0, pc_stall}, 32'h1);
    chk("trap_flush", {31'h0, flush_if}, 32'h1);
    step(); br_taken = 1'b0; trap_cause = 4'h5; #1;
    chk("trap_epc", epc, 32'h60);
    chk("trap_cause", {28'h0, cause}, 32'h3);
    chk("trap_vec_next", pc_next, 32'h80);
    chk("trap_vec_stall", {31'h0, pc_stall}, 32'h0);
    chk("trap_vec_flush", {31'h0, flush_if}, 32'h1);
    // Nested trap request inside the handler is ignored
    step(); pc_cur = 32'h80; trap_cause = 4'h7; #1;
    chk("hdl_in_trap", {31'h0, in_trap}, 32'h1);
    chk("hdl_cause_kept", {28'h0, cause}, 32'h3);
    chk("hdl_epc_kept", epc, 32'h60);
    chk("nest_next", pc_next, 32'h84);
    chk("nest_flush", {31'h0, flush_if}, 32'h0);

    // eret beats jump and branch in the same cycle
    step(); trap_req = 1'b0; pc_cur = 32'h84; eret = 1'b1;
    jmp_valid = 1'b1; jmp_target = 32'h200; br_taken = 1'b1; br_target = 32'h100; #1;
    chk("eret_prio_next", pc_next, 32'h60);
    chk("eret_prio_flush", {31'h0, flush_if}, 32'h1);
    chk("eret_prio_stall", {31'h0, pc_stall}, 32'h0);
    step(); idle_inputs(); pc_cur = 32'h60; #1;
    chk("eret_in_trap", {31'h0, in_trap}, 32'h0);
    chk("eret_post_next", pc_next, 32'h64);

    // Trap while a redirect is parked: epc takes the parked target
    step(); pc_cur = 32'h10; br_taken = 1'b1; br_target = 32'h300; imem_busy = 1'b1; #1;
    chk("hold_br_stall", {31'h0, pc_stall}, 32'h1);
    chk("hold_br_flush", {31'h0, flush_if}, 32'h0);
    step(); br_taken = 1'b0; trap_req = 1'b1; trap_cause = 4'h9; #1;
    chk("hold_trap_stall", {31'h0, pc_stall}, 32'h1);
    step(); trap_req = 1'b0; #1;
    chk("hold_trap_epc", epc, 32'h300);
    chk("hold_trap_cause", {28'h0, cause}, 32'h9);
    chk("trap_busy_stall", {31'h0, pc_stall}, 32'h1);
    chk("trap_busy_flush", {31'h0, flush_if}, 32'h0);
    step(); imem_busy = 1'b0; #1;
    chk("trap2_vec_next", pc_next, 32'h80);
    chk("trap2_vec_flush", {31'h0, flush_if}, 32'h1);

    // Stalled eret: in_trap clears only when the parked eret is released
    step(); pc_cur = 32'h80; eret = 1'b1; hazard_stall = 1'b1; #1;
    chk("eret_h_in_trap", {31'h0, in_trap}, 32'h1);
    chk("eret_h_stall", {31'h0, pc_stall}, 32'h1);
    step(); eret = 1'b0; #1;
    chk("eret_h2_in_trap", {31'h0, in_trap}, 32'h1);
    chk("eret_h2_flush", {31'h0, flush_if}, 32'h0);
    step(); hazard_stall = 1'b0; #1;
    chk("eret_rel_next", pc_next, 32'h300);
    chk("eret_rel_flush", {31'h0, flush_if}, 32'h1);
    step(); pc_cur = 32'h300; #1;
    chk("eret_rel_in_trap", {31'h0, in_trap}, 32'h0);
    chk("eret_rel_post", pc_next, 32'h304);

    // Long hazard stall
`ifdef PCSEQ_STALL_TIMEOUT_EN
    for (int i = 0; i < 15; i++) begin
      step(); hazard_stall = 1'b1; #1;
      chk("tmo_wait_stall", {31'h0, pc_stall}, 32'h1);
      chk("tmo_wait_flush", {31'h0, flush_if}, 32'h0);
    end
    step(); #1;
    chk("tmo_fire_flush", {31'h0, flush_if}, 32'h1);
    step(); #1;
    chk("tmo_cause", {28'h0, cause}, 32'hF);
    chk("tmo_epc", epc, 32'h300);
    chk("tmo_vec_next", pc_next, 32'h80);
    chk("tmo_vec_flush", {31'h0, flush_if}, 32'h1);
`else
    for (int i = 0; i < 20; i++) begin
      step(); hazard_stall = 1'b1; #1;
      chk("nostall_tmo_stall", {31'h0, pc_stall}, 32'h1);
      chk("nostall_tmo_flush", {31'h0, flush_if}, 32'h0);
    end
    chk("nostall_tmo_cause", {28'h0, cause}, 32'h9);
    chk("nostall_tmo_in_trap", {31'h0, in_trap}, 32'h0);
`endif

    // Asynchronous reset in HOLD discards the parked redirect
    step(); pc_cur = 32'h300; hazard_stall = 1'b1; jmp_valid = 1'b1; jmp_target = 32'h500; #1;
    step(); jmp_valid = 1'b0; #1;
    rst = 1'b0; #1;
    chk("arst_next", pc_next, 32'h0);
    chk("arst_stall", {31'h0, pc_stall}, 32'h1);
    chk("arst_flush", {31'h0, flush_if}, 32'h0);
    chk("arst_epc", epc, 32'h0);
    chk("arst_cause", {28'h0, cause}, 32'h0);
    chk("arst_in_trap", {31'h0, in_trap}, 32'h0);
    step(); rst = 1'b1; hazard_stall = 1'b0; pc_cur = 32'h20; #1;
    chk("arst_rel_next", pc_next, 32'h24);
    chk("arst_rel_flush", {31'h0, flush_if}, 32'h0);
    chk("arst_rel_stall", {31'h0, pc_stall}, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pc_seq_ctrl.md
Name: pc_seq_ctrl

Overview:
- Next-PC sequencer and stall controller for the fetch-stage PC register.
- Each cycle it drives that register's next-PC input (pc_next) and stall input (pc_stall).
- It arbitrates sequential fetch, branch, jump, exception-return and trap redirects, and holds a redirect that arrives while the pipeline is frozen.
- It owns the EPC/cause registers and the single-level trap state.

Parameters:
- RESET_PC, 32'h0000_0000: pc_next value while rst is asserted.
- TRAP_VECTOR, 32'h0000_0080: trap handler entry address.
- STALL_LIMIT, 16: stall-timeout threshold in cycles; used only when PCSEQ_STALL_TIMEOUT_EN is defined.

Ports:
- clk, in, 1: clock, rising edge.
- rst, in, 1: asynchronous reset, active-low.
- pc_cur, in, 32: current PC (PC register output).
- hazard_stall, in, 1: stall request from hazard unit.
- imem_busy, in, 1: instruction memory not ready.
- br_taken, in, 1: resolved taken branch this cycle.
- br_target, in, 32: branch target.
- jmp_valid, in, 1: jump this cycle.
- jmp_target, in, 32: jump target.
- eret, in, 1: exception return.
- trap_req, in, 1: trap request.
- trap_cause, in, 4: trap cause code.
- pc_next, out, 32: next PC (to PC register input).
- pc_stall, out, 1: hold PC (to PC register stall input).
- flush_if, out, 1: squash the IF/ID instruction this cycle.
- epc, out, 32: saved exception PC.
- cause, out, 4: saved trap cause.
- in_trap, out, 1: handler active; nested traps are masked.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=RUN; epc=0; cause=0; in_trap=0; pend_valid=0; pend_target=0.
  - Outputs while rst=0: pc_next=RESET_PC, pc_stall=1, flush_if=0.
- Definitions:
  - stall = hazard_stall | imem_busy.
  - Redirect priority, high to low: eret (target=epc), jmp_valid (jmp_target), br_taken (br_target).
  - Default pc_next = pc_cur + 32'd4, modulo 2^32 (0xFFFF_FFFC wraps to 0).
- pc_next, pc_stall and flush_if are combinational from state and inputs. All other state is registered on the rising edge of clk.
- RUN state:
  - trap_req & ~in_trap: epc<=pc_cur, cause<=trap_cause, go TRAP. Outputs: pc_stall=1, flush_if=1. This applies even if stall=1 or a redirect is present (trap wins).
  - trap_req & in_trap: ignored.
  - Redirect & ~stall: pc_next=target, pc_stall=0, flush_if=1. If the redirect is eret, in_trap<=0.
  - Redirect & stall: pend_target<=target, pend_valid<=1, pend_eret<=eret, go HOLD. Outputs: pc_stall=1, flush_if=0.
  - No redirect: pc_stall=stall, flush_if=0.
- HOLD state:
  - Outputs while stall=1: pc_stall=1, flush_if=0.
  - New redirect inputs are ignored.
  - On the first cycle with stall=0: pc_next=pend_target, pc_stall=0, flush_if=1, pend_valid<=0, go RUN. If pend_eret=1, in_trap<=0.
  - trap_req & ~in_trap in HOLD: epc<=pend_target, cause<=trap_cause, pend_valid<=0, go TRAP.
- TRAP state:
  - While imem_busy=1: pc_stall=1.
  - Otherwise: pc_next=TRAP_VECTOR, pc_stall=0, flush_if=1, in_trap<=1, go RUN.
  - hazard_stall, trap_req and redirects are ignored.
- Latencies:
  - Redirect in RUN: PC register holds target one clock later.
  - Trap: handler fetch begins 2 clocks after trap_req when imem_busy=0.
- A reset in any state aborts immediately; pending redirect and trap info are discarded.

Optional Feature:
- Macro: PCSEQ_STALL_TIMEOUT_EN.
- Defined:
  - A 16-bit counter increments each cycle pc_stall=1 in RUN or HOLD, and clears when pc_stall=0 or the state changes.
  - When the count reaches STALL_LIMIT-1 and in_trap=0, a trap is forced with cause=4'hF. epc follows the normal trap-entry rules for that state.
  - Counter reset value is 0.
- Undefined: no counter; stalls may last indefinitely.

Test Plan:
- Reset release, no stalls, pc_cur following pc_next from 0 -> pc_next sequence 4, 8, 12; flush_if stays 0.
- pc_cur=0x40, br_taken=1, br_target=0x100, stall=0 -> same cycle pc_next=0x100, flush_if=1, pc_stall=0.
- pc_cur=0x40, jmp_valid=1 (jmp_target=0x200) with hazard_stall=1 held 3 cycles -> pc_stall=1 for 3 cycles, then pc_next=0x200, flush_if=1 for exactly one cycle.
- pc_cur=0x60, trap_req=1, cause=4'h3 -> next cycle epc=0x60, cause=3; following cycle pc_next=0x80, in_trap=1. A second trap_req is ignored. eret -> pc_next=0x60, in_trap=0.
- Simultaneous eret, jmp_valid and br_taken in RUN with epc=0x60 -> pc_next=0x60; branch and jump targets discarded.
- With PCSEQ_STALL_TIMEOUT_EN and hazard_stall held high -> after 16 stall cycles, trap entry with cause=4'hF and pc_next=0x80. Without the macro: stall persists with no trap.
